// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants, FSM states and the one-hot to index mapping
package rr_arb_pkg;
  localparam int NREQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first request after i_last_idx wins
import rr_arb_pkg::*;
module rr_pick (
  input  logic [NREQ-1:0]  i_req_eff,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic             o_found,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx
);
  always_comb begin
    o_onehot = '0;
    // farthest offset first so the nearest requester after i_last_idx overwrites
    for (int k = NREQ; k >= 1; k--)
      if (i_req_eff[IDX_W'(i_last_idx + IDX_W'(k))])
        o_onehot = NREQ'(1) << IDX_W'(i_last_idx + IDX_W'(k));
  end
  assign o_found = |o_onehot;
  assign o_idx = onehot_to_idx(o_onehot);
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with registered one-hot grant and valid/ready hold.
// ARB_REQ_LATCH_EN adds a pending register so single-cycle request pulses are never lost.
module rr_onehot_arbiter #(
  parameter int NREQ = rr_arb_pkg::NREQ,
  parameter int IDX_W = rr_arb_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
);
  import rr_arb_pkg::*;
  if (NREQ != 4 || IDX_W != 2) begin : g_bad_cfg
    $error("rr_onehot_arbiter supports only NREQ=4, IDX_W=2");
  end
  state_t r_state, w_state_nx;
  logic [NREQ-1:0] r_onehot, w_onehot_nx, w_eff, w_pick_oh;
  logic [IDX_W-1:0] r_idx, r_last, w_idx_nx, w_last_nx, w_pick_idx;
  logic w_accept, w_load, w_found;
  assign w_accept = (r_state == ST_GRANT) && gnt_ready;
  assign w_load = (r_state == ST_IDLE) || w_accept;
`ifdef ARB_REQ_LATCH_EN
  logic [NREQ-1:0] r_pend, w_pend_nx;
  // new req on the accepted bit re-sets its flag (set wins over clear)
  assign w_pend_nx = (r_pend & ~(w_accept ? r_onehot : '0)) | req;
  assign w_eff = w_pend_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pend <= '0;
    else r_pend <= w_pend_nx;
`else
  assign w_eff = req;
`endif
  // on accept the next pick already treats the served index as the last one
  assign w_last_nx = w_accept ? r_idx : r_last;
  rr_pick u_pick (
    .i_req_eff (w_eff),
    .i_last_idx(w_last_nx),
    .o_found   (w_found),
    .o_onehot  (w_pick_oh),
    .o_idx     (w_pick_idx)
  );
  always_comb begin
    w_state_nx = w_load ? (w_found ? ST_GRANT : ST_IDLE) : r_state;
    w_onehot_nx = w_load ? w_pick_oh : r_onehot;
    w_idx_nx = (w_load && w_found) ? w_pick_idx : r_idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_onehot <= '0;
      r_idx <= '0;
      r_last <= '1;
    end else begin
      r_state <= w_state_nx;
      r_onehot <= w_onehot_nx;
      r_idx <= w_idx_nx;
      r_last <= w_last_nx;
    end
  assign gnt_valid = (r_state == ST_GRANT);
  assign busy = (r_state == ST_GRANT);
  assign gnt_onehot = r_onehot;
  assign gnt_idx = r_idx;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed vector table, corner sequences and a randomized model comparison
module tb_rr_onehot_arbiter;
  logic clk, rst_n, gnt_ready, gnt_valid, busy;
  logic [3:0] req, gnt_onehot;
  logic [1:0] gnt_idx;
  int n_err = 0, n_chk = 0;

  rr_onehot_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt_valid (gnt_valid),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .busy      (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    int         ei;
  } vec_t;
  vec_t tbl[$];

  logic m_valid;
  int m_idx, m_last;
  logic [3:0] m_pend;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic v, input int idx);
    logic [3:0] oh;
    oh = v ? (4'b0001 << idx) : 4'b0000;
    chk({nm, ".valid"}, {7'd0, gnt_valid}, {7'd0, v});
    chk({nm, ".onehot"}, {4'd0, gnt_onehot}, {4'd0, oh});
    chk({nm, ".idx"}, {6'd0, gnt_idx}, 8'(idx));
    chk({nm, ".busy"}, {7'd0, busy}, {7'd0, v});
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #3 rst_n = 0;
    #1 check_out({nm, ".rst"}, 1'b0, 0);
    #1 rst_n = 1;
    m_valid = 0; m_idx = 0; m_last = 3; m_pend = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // reference: scan the effective requests starting after the last served index
  task automatic model_step;
    logic [3:0] eff;
    bit acc;
    acc = m_valid && gnt_ready;
`ifdef ARB_REQ_LATCH_EN
    eff = (acc ? (m_pend & ~(4'b0001 << m_idx)) : m_pend) | req;
    m_pend = eff;
`else
    eff = req;
`endif
    if (acc) m_last = m_idx;
    if (!m_valid || acc) begin
      m_valid = 0;
      for (int off = 1; off <= 4; off++)
        if (!m_valid && eff[(m_last + off) % 4]) begin
          m_valid = 1;
          m_idx = (m_last + off) % 4;
        end
    end
  endtask

  initial begin
    rst_n = 0; req = '0; gnt_ready = 0;
    // hold after a single request, then release
    tbl.push_back('{1, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 4'b0001, 0, 1, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 4'b0000, 0, 1, 0});
    tbl.push_back('{0, 4'b0000, 1, 0, 0});
    // all requesting, continuous accept: rotation with no bubble
    tbl.push_back('{1, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 4'b1111, 0, 1, 0});
    for (int i = 1; i <= 6; i++) tbl.push_back('{0, 4'b1111, 1, 1, i % 4});
    // wrap past 3 after serving 2
    tbl.push_back('{1, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 4'b0100, 0, 1, 2});
    tbl.push_back('{0, 4'b0101, 1, 1, 0});
    // sole requester re-granted each cycle; ready while idle ignored
    tbl.push_back('{1, 4'b0000, 0, 0, 0});
    tbl.push_back('{0, 4'b0000, 1, 0, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 4'b0010, 1, 1, 1});
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("tbl%0d", i));
      else begin
        req = tbl[i].req;
        gnt_ready = tbl[i].rdy;
        step();
        check_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ei);
      end
    end

    // asynchronous reset in the middle of a held grant
    do_reset("mid0");
    req = 4'b0100; gnt_ready = 0;
    step();
    check_out("mid.grant", 1, 2);
    do_reset("mid1");
    req = 4'b1001;
    step();
    check_out("mid.after", 1, 0);

    // one-cycle pulse on req[3] while idx 0 is held
    do_reset("pulse");
    req = 4'b0001; gnt_ready = 0;
    step();
    check_out("pulse.g0", 1, 0);
    req = 4'b1000;
    step();
    check_out("pulse.hold", 1, 0);
    req = 4'b0000; gnt_ready = 1;
    step();
`ifdef ARB_REQ_LATCH_EN
    check_out("pulse.acc", 1, 3);
`else
    check_out("pulse.acc", 0, 0);
`endif

    // randomized traffic against the reference model
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) do_reset($sformatf("rnd%0d", i));
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      gnt_ready = ($urandom_range(0, 2) != 0);
      model_step();
      step();
      check_out($sformatf("rnd%0d", i), m_valid, m_idx);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
